cassette_rec: RTL

Cassette recorder for the CoCo3 core: the write-side counterpart of the cassette player. While the cassette relay is closed, it watches the 6-bit sound DAC, demodulates the CoCo FSK tape signal (one cycle per bit, 2400 Hz = 1, 1200 Hz = 0, LSB first) into bytes, and writes them sequentially into the tape SRAM. A later CAS download or playback reads the same byte stream.

---
 rtl/cassette_pkg.sv | 18 +
 rtl/cassette_rec_if.sv | 11 +
 rtl/cas_fsk_demod.sv | 69 ++++++
 rtl/cassette_rec.sv | 122 ++++++++++++
 4 files changed

// File: rtl/cassette_pkg.sv
// Shared cassette timing constants and FSM state type.
// The player reuses the timing constants from here.
package cassette_pkg;

    localparam int unsigned CAS_HI_TH      = 36;
    localparam int unsigned CAS_LO_TH      = 28;
    localparam int unsigned CAS_MIN_PERIOD = 250;
    localparam int unsigned CAS_BIT_THRESH = 560;
    localparam int unsigned CAS_MAX_PERIOD = 1000;
    localparam int unsigned CAS_CNT_W      = 11;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        MEASURE
    } cas_state_e;

endpackage

// File: rtl/cassette_rec_if.sv
// SRAM write port of the cassette recorder.
interface cassette_rec_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_data;
    logic              sram_wr;

    modport master (output sram_addr, output sram_data, output sram_wr);
    modport slave  (input sram_addr, input sram_data, input sram_wr);
endinterface

// File: rtl/cas_fsk_demod.sv
// FSK front end: hysteresis comparator, Q-rate period counter and
// per-edge bit classifier.
module cas_fsk_demod
    import cassette_pkg::*;
#(
    parameter int unsigned HI_TH      = CAS_HI_TH,
    parameter int unsigned LO_TH      = CAS_LO_TH,
    parameter int unsigned MIN_PERIOD = CAS_MIN_PERIOD,
    parameter int unsigned BIT_THRESH = CAS_BIT_THRESH,
    parameter int unsigned MAX_PERIOD = CAS_MAX_PERIOD
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Q,
    input  logic       en,
    input  logic       measuring,
    input  logic [5:0] dac_in,
    output logic       edge_det,
    output logic       bit_valid,
    output logic       bit_val,
    output logic       gap
);

    localparam logic [5:0]           HI_LVL = 6'(HI_TH);
    localparam logic [5:0]           LO_LVL = 6'(LO_TH);
    localparam logic [CAS_CNT_W-1:0] MIN_P  = CAS_CNT_W'(MIN_PERIOD);
    localparam logic [CAS_CNT_W-1:0] BIT_P  = CAS_CNT_W'(BIT_THRESH);
    localparam logic [CAS_CNT_W-1:0] MAX_P  = CAS_CNT_W'(MAX_PERIOD);

    logic                 cmp_q, cmp_prev_q;
    logic [CAS_CNT_W-1:0] cnt_q, cnt_d;
    logic                 short_p, accept;

    assign edge_det = cmp_q & ~cmp_prev_q;
    assign short_p  = cnt_q < MIN_P;
    // Short edges while measuring are glitches: the counter keeps running across them.
    assign accept   = en & edge_det & (~measuring | ~short_p);
    assign gap      = measuring & (cnt_q > MAX_P);

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = {{(CAS_CNT_W-1){1'b0}}, Q};
        end else if (en && Q && cnt_q != '1) begin
            cnt_d = cnt_q + CAS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_q      <= 1'b0;
            cmp_prev_q <= 1'b0;
            cnt_q      <= '0;
            bit_valid  <= 1'b0;
            bit_val    <= 1'b0;
        end else begin
            if (dac_in >= HI_LVL) begin
                cmp_q <= 1'b1;
            end else if (dac_in <= LO_LVL) begin
                cmp_q <= 1'b0;
            end
            cmp_prev_q <= cmp_q;
            cnt_q      <= cnt_d;
            bit_valid  <= en & measuring & edge_det & ~short_p & (cnt_q <= MAX_P);
            bit_val    <= cnt_q <= BIT_P;
        end
    end

endmodule

// File: rtl/cassette_rec.sv
// Cassette recorder: demodulates the sound DAC FSK stream into bytes and
// writes them sequentially into the tape SRAM.
module cassette_rec
    import cassette_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned HI_TH      = CAS_HI_TH,
    parameter int unsigned LO_TH      = CAS_LO_TH,
    parameter int unsigned MIN_PERIOD = CAS_MIN_PERIOD,
    parameter int unsigned BIT_THRESH = CAS_BIT_THRESH,
    parameter int unsigned MAX_PERIOD = CAS_MAX_PERIOD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Q,
    input  logic              en,
    input  logic              rewind,
    input  logic [5:0]        dac_in,
    cassette_rec_if.master    sram,
    output logic [ADDR_W-1:0] byte_count,
    output logic              full,
    output logic              active
);

    cas_state_e        state_q;
    logic [7:0]        sr_q, sr_nxt, data_q;
    logic [2:0]        bcnt_q;
    logic [ADDR_W-1:0] ptr_q, addr_q;
    logic              full_q, wr_q;
    logic              edge_det, bit_valid, bit_val, gap;
    logic              measuring, take_bit, do_wr;

    cas_fsk_demod #(
        .HI_TH      (HI_TH),
        .LO_TH      (LO_TH),
        .MIN_PERIOD (MIN_PERIOD),
        .BIT_THRESH (BIT_THRESH),
        .MAX_PERIOD (MAX_PERIOD)
    ) u_demod (
        .clk       (clk),
        .reset_n   (reset_n),
        .Q         (Q),
        .en        (en),
        .measuring (measuring),
        .dac_in    (dac_in),
        .edge_det  (edge_det),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .gap       (gap)
    );

    assign measuring = state_q == MEASURE;
    assign sr_nxt    = {bit_val, sr_q[7:1]};
    assign take_bit  = measuring & en & ~rewind & ~gap & bit_valid;
    assign do_wr     = take_bit & (bcnt_q == 3'd7) & ~full_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bcnt_q  <= '0;
            ptr_q   <= '0;
            full_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            wr_q <= do_wr;
            if (do_wr) begin
                addr_q <= ptr_q;
                data_q <= sr_nxt;
            end
            // Pointer advances the clk after the strobe; it parks on the last address.
            if (rewind) begin
                ptr_q  <= '0;
                full_q <= 1'b0;
            end else if (wr_q) begin
                if (ptr_q == '1) begin
                    full_q <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                end
            end

            if (!en) begin
                state_q <= IDLE;
                sr_q    <= '0;
                bcnt_q  <= '0;
            end else if (rewind) begin
                state_q <= SYNC;
                sr_q    <= '0;
                bcnt_q  <= '0;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= SYNC;
                    SYNC: begin
                        if (edge_det) state_q <= MEASURE;
                    end
                    MEASURE: begin
                        if (gap) begin
                            state_q <= SYNC;
                            sr_q    <= '0;
                            bcnt_q  <= '0;
                        end else if (take_bit) begin
                            sr_q   <= sr_nxt;
                            bcnt_q <= bcnt_q + 3'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sram.sram_wr   = wr_q;
    assign sram.sram_addr = addr_q;
    assign sram.sram_data = data_q;
    assign byte_count     = ptr_q;
    assign full           = full_q;
    assign active         = measuring;

endmodule
